// File: rtl/top_key_arb_pkg.sv
// top_key_arb_pkg: shared types, constants and the round-robin pick function for top_key_arb.
package top_key_arb_pkg;
  typedef enum logic {IDLE, BUSY} top_key_arb_state_e;
  localparam int keydata_width_p = 9;
  localparam int last_bit_p = 8;
  // First valid index at or after ptr, modulo n (n <= 16); returns ptr when nothing is valid.
  function automatic logic [3:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr, input logic [4:0] n);
    logic [4:0] k;
    rr_pick = ptr;
    for (int i = 15; i >= 0; i--) begin
      k = {1'b0, ptr} + 5'(i);
      k = (k >= n) ? k - n : k;
      if (5'(i) < n && valid[k[3:0]]) rr_pick = k[3:0];
    end
  endfunction
endpackage

// File: rtl/top_key_arb_rrsel.sv
// top_key_arb_rrsel: combinational round-robin selector.
//   valid_i  : request vector
//   ptr_i    : round-robin pointer (search starts here)
//   idx_o    : selected index
//   onehot_o : selected index as one-hot
//   any_o    : at least one request valid
module top_key_arb_rrsel
  import top_key_arb_pkg::*;
#(
  parameter int req_num_p = 4
) (
  input  logic [req_num_p-1:0] valid_i,
  input  logic [3:0]           ptr_i,
  output logic [3:0]           idx_o,
  output logic [req_num_p-1:0] onehot_o,
  output logic                 any_o
);
  localparam logic [req_num_p-1:0] one_c = 1;
  assign idx_o = rr_pick(16'(valid_i), ptr_i, 5'(req_num_p));
  assign onehot_o = one_c << idx_o;
  assign any_o = |valid_i;
endmodule

// File: rtl/top_key_arb.sv
// top_key_arb: packet-granular round-robin arbiter in front of the top_core key stream.
//   main_clk_i / main_rst_an_i : clock, synchronous active-low reset
//   req_valid_i / req_accept_o / req_data_i : requester side, data bit 8 = last beat
//   key_valid_o / key_accept_i / key_data_o : towards top_core
//   grant_o : one-hot current grant, busy_o : packet in progress, err_o : forced-release pulse
// Optional: define TOP_KEY_ARB_PRIO_EN to make requester 0 win every arbitration
// without advancing the round-robin pointer.
module top_key_arb
  import top_key_arb_pkg::*;
#(
  parameter int req_num_p  = 4,
  parameter int maxbeats_p = 16
) (
  input  logic                       main_clk_i,
  input  logic                       main_rst_an_i,
  input  logic [req_num_p-1:0]       req_valid_i,
  output logic [req_num_p-1:0]       req_accept_o,
  input  logic [keydata_width_p-1:0] req_data_i [0:req_num_p-1],
  output logic                       key_valid_o,
  input  logic                       key_accept_i,
  output logic [keydata_width_p-1:0] key_data_o,
  output logic [req_num_p-1:0]       grant_o,
  output logic                       busy_o,
  output logic                       err_o
);
  top_key_arb_state_e state_q, state_d;
  logic [req_num_p-1:0] grant_q, grant_d, rr_oh, pick_oh;
  logic [3:0] g_q, g_d, ptr_q, ptr_d, rr_idx, pick_idx, ptr_nxt;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic err_q, err_d, any_v, keep_ptr, beat, last, hit;
  top_key_arb_rrsel #(.req_num_p(req_num_p)) u_rrsel (
    .valid_i  (req_valid_i),
    .ptr_i    (ptr_q),
    .idx_o    (rr_idx),
    .onehot_o (rr_oh),
    .any_o    (any_v)
  );
`ifdef TOP_KEY_ARB_PRIO_EN
  localparam logic [req_num_p-1:0] one_c = 1;
  assign pick_idx = req_valid_i[0] ? 4'd0 : rr_idx;
  assign pick_oh  = req_valid_i[0] ? one_c : rr_oh;
  assign keep_ptr = (g_q == 4'd0);
`else
  assign pick_idx = rr_idx;
  assign pick_oh  = rr_oh;
  assign keep_ptr = 1'b0;
`endif
  // grant_q is zero outside BUSY, so the one-hot mux also covers the idle case
  always_comb begin
    key_valid_o = 1'b0;
    key_data_o = '0;
    req_accept_o = '0;
    for (int i = 0; i < req_num_p; i++) begin
      if (grant_q[i]) begin
        key_valid_o = req_valid_i[i];
        key_data_o = req_valid_i[i] ? req_data_i[i] : '0;
        req_accept_o[i] = key_accept_i;
      end
    end
  end
  assign beat = key_valid_o & key_accept_i;
  assign last = key_data_o[last_bit_p];
  assign cnt_inc = cnt_q + 8'd1;
  assign hit = (cnt_inc == 8'(maxbeats_p));
  assign ptr_nxt = (g_q == 4'(req_num_p - 1)) ? 4'd0 : g_q + 4'd1;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    g_d = g_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      if (any_v) begin
        state_d = BUSY;
        grant_d = pick_oh;
        g_d = pick_idx;
      end
    end else if (beat) begin
      cnt_d = cnt_inc;
      if (last | hit) begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d = '0;
        err_d = ~last;
        ptr_d = keep_ptr ? ptr_q : ptr_nxt;
      end
    end
  end
  always_ff @(posedge main_clk_i) begin
    if (!main_rst_an_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      g_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      g_q <= g_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign grant_o = grant_q;
  assign busy_o = (state_q == BUSY);
  assign err_o = err_q;
endmodule

// File: doc/top_key_arb.md
Name: top_key_arb

Overview:
- Round-robin arbiter sharing the single key stream of top_core (key_valid/key_accept/key_data, 9 bit) between req_num_p requesters.
- key_data[8] is the last-beat flag; the grant is held for a whole packet, up to and including the accepted beat with data[8]=1.
- A beat counter force-releases grants on overlong packets, so one requester cannot starve the others.
- Sits between requester sources and top_core.key_i, in main clock domain.

Parameters:
- req_num_p, 4, number of requesters (2..16)
- maxbeats_p, 16, maximum beats per packet before forced release (2..255)

Ports:
- main_clk_i  in  1  clock
- main_rst_an_i  in  1  reset; one clock; reset is synchronous and active-low
- req_valid_i  in  req_num_p  per-requester valid
- req_accept_o  out  req_num_p  per-requester accept
- req_data_i  in  [8:0] x [0:req_num_p-1] (unpacked)  per-requester data; bit 8 = last
- key_valid_o  out  1  to top_core key_valid_i
- key_accept_i  in  1  from top_core key_accept_o
- key_data_o  out  9  to top_core key_data_i
- grant_o  out  req_num_p  one-hot current grant, 0 when idle
- busy_o  out  1  packet in progress
- err_o  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (main_rst_an_i=0 at a rising edge): state=IDLE, grant_o=0, rr pointer=0, beat counter=0, err_o=0. Combinational outputs then read key_valid_o=0, req_accept_o=0, key_data_o=0.
- Reset mid-packet drops the grant immediately. The downstream sees valid fall; this is permitted only under reset.
- FSM IDLE:
  - If any req_valid_i is set, pick the first requester at or after rr pointer (modulo req_num_p).
  - Register its one-hot grant and go to BUSY.
  - One-cycle arbitration bubble: first beat is presented one cycle after the requester's valid rises.
- FSM BUSY (granted index g), pure combinational pass-through:
  - key_valid_o = req_valid_i[g]
  - key_data_o = req_data_i[g]
  - req_accept_o[g] = key_accept_i; all other req_accept_o = 0
  - key_data_o = 0 when key_valid_o = 0
- Beat = key_valid_o & key_accept_i in the same cycle. On each beat, beat counter increments (8 bit, saturating not needed since capped).
- Release: on a beat with data[8]=1, or on a beat that makes counter == maxbeats_p.
  - Next cycle: IDLE, grant_o=0, counter=0, rr pointer = g+1 (wrap to 0 at req_num_p).
  - Forced release (counter reached maxbeats_p without last) pulses err_o for exactly one cycle, coincident with the return to IDLE.
  - Last flag on beat number maxbeats_p is a normal release; no err_o.
- Granted requester dropping valid while in BUSY: the grant is held; no timeout on idle cycles.
- Back-to-back packets: minimum one IDLE cycle between packets (release cycle, then arbitrate). Throughput bound: N beats per N+1 cycles.
- Single requester always valid: same requester regranted each time, since the pointer wraps back to it.
- busy_o = (state==BUSY).

Optional Feature:
- Macro: TOP_KEY_ARB_PRIO_EN.
- Defined: requester 0 is high priority. In IDLE, if req_valid_i[0]=1, it wins regardless of rr pointer, and the rr pointer is not updated after its packet. Other requesters use round-robin as normal.
- Not defined: pure round-robin as above, with no extra logic.

Decomposition:
- Package top_key_arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} top_key_arb_state_e
  - localparam keydata_width_p=9
  - localparam last_bit_p=8
  - function rr_pick(valid, ptr) returning an index
- One sub-module is natural: top_key_arb_rrsel, the combinational round-robin selector (valid vector plus pointer in, one-hot plus index out). The FSM and counter stay in top_key_arb.

Test Plan:
- Reset: hold main_rst_an_i=0 for 3 cycles with all req_valid_i=1 -> grant_o=0, key_valid_o=0, err_o=0 throughout.
- Round-robin: req_valid_i=4'b1111, each sends a 2-beat packet (data 0x001, 0x1FF), key_accept_i=1 -> grant order 0,1,2,3,0, one idle cycle between packets.
- Backpressure: requester 2 valid, key_accept_i toggling 0/1 -> key_data_o stable while accept=0; req_accept_o=4'b0100 only when key_accept_i=1.
- Forced release: requester 1 sends 16 beats, none with bit 8 set, maxbeats_p=16 -> err_o=1 for one cycle after beat 16; the next grant goes to requester 2 if valid.
- Reset mid-packet: assert reset after beat 3 -> next cycle grant_o=0, counter=0; after reset, arbitration restarts at requester 0.
- PRIO_EN build: requester 0 and requester 3 valid, pointer=3 -> requester 0 granted first; pointer still 3 afterwards, so requester 3 is granted next.
